// File: rtl/wm_led_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wm_led_pkg
//  Description : Shared mode encodings, field widths and mode helpers for the
//                washing-machine front-panel LED controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package wm_led_pkg;

    localparam int MODE_W    = 3;
    localparam int DUTY_W    = 4;
    localparam int ONESHOT_W = 10;

    typedef enum logic [MODE_W-1:0] {
        WM_LED_OFF     = 3'd0,
        WM_LED_ON      = 3'd1,
        WM_LED_SLOW    = 3'd2,
        WM_LED_FAST    = 3'd3,
        WM_LED_ONESHOT = 3'd4
    } wm_led_mode_t;

    // Codes 5..7 are not real modes; they are stored as OFF so a later
    // read-back never shows an undefined encoding.
    function automatic wm_led_mode_t decode_mode(input logic [MODE_W-1:0] code);
        case (code)
            3'd1:    return WM_LED_ON;
            3'd2:    return WM_LED_SLOW;
            3'd3:    return WM_LED_FAST;
            3'd4:    return WM_LED_ONESHOT;
            default: return WM_LED_OFF;
        endcase
    endfunction

    // Un-dimmed lit state of a channel given its mode and the shared phases.
    function automatic logic mode_lit(input wm_led_mode_t mode,
                                      input logic         slow_phase,
                                      input logic         fast_phase);
        logic lit;
        lit = 1'b0;
        case (mode)
            WM_LED_ON:      lit = 1'b1;
            WM_LED_SLOW:    lit = slow_phase;
            WM_LED_FAST:    lit = fast_phase;
            WM_LED_ONESHOT: lit = 1'b1;
            default:        lit = 1'b0;
        endcase
        return lit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wm_led_timebase.sv
`default_nettype none
// ============================================================================
//  Module      : wm_led_timebase
//  Description : 1 ms prescaler with tick output plus the global slow and
//                fast blink phase generators shared by every LED channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_led_timebase #(
    parameter int CNT_1MSEC     = 125000,
    parameter int BLINK_SLOW_MS = 500,
    parameter int BLINK_FAST_MS = 125
) (
    input  logic clk,
    input  logic rstn,
    output logic tick_1ms,
    output logic slow_phase,
    output logic fast_phase
);

    localparam int c_ms_w   = $clog2(CNT_1MSEC + 1);
    localparam int c_slow_w = $clog2(BLINK_SLOW_MS + 1);
    localparam int c_fast_w = $clog2(BLINK_FAST_MS + 1);

    localparam logic [c_ms_w-1:0]   c_ms_last   = c_ms_w'(CNT_1MSEC - 1);
    localparam logic [c_slow_w-1:0] c_slow_last = c_slow_w'(BLINK_SLOW_MS - 1);
    localparam logic [c_fast_w-1:0] c_fast_last = c_fast_w'(BLINK_FAST_MS - 1);

    logic [c_ms_w-1:0]   r_ms_cnt;
    logic [c_slow_w-1:0] r_slow_cnt;
    logic [c_fast_w-1:0] r_fast_cnt;
    logic                r_slow_phase;
    logic                r_fast_phase;
    logic                w_tick;

    // The tick is decoded from the registered count, so it is high for the
    // whole cycle in which the count sits at its last value.
    assign w_tick = (r_ms_cnt == c_ms_last);

    // Free-running ms prescaler, 0..CNT_1MSEC-1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ms_cnt <= '0;
        end else if (w_tick) begin
            r_ms_cnt <= '0;
        end else begin
            r_ms_cnt <= r_ms_cnt + 1'b1;
        end
    end

    // Slow phase flips at the edge that ends every BLINK_SLOW_MS-th tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_slow_cnt   <= '0;
            r_slow_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_slow_cnt == c_slow_last) begin
                r_slow_cnt   <= '0;
                r_slow_phase <= ~r_slow_phase;
            end else begin
                r_slow_cnt <= r_slow_cnt + 1'b1;
            end
        end
    end

    // Fast phase flips at the edge that ends every BLINK_FAST_MS-th tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fast_cnt   <= '0;
            r_fast_phase <= 1'b0;
        end else if (w_tick) begin
            if (r_fast_cnt == c_fast_last) begin
                r_fast_cnt   <= '0;
                r_fast_phase <= ~r_fast_phase;
            end else begin
                r_fast_cnt <= r_fast_cnt + 1'b1;
            end
        end
    end

    assign tick_1ms   = w_tick;
    assign slow_phase = r_slow_phase;
    assign fast_phase = r_fast_phase;

endmodule
`default_nettype wire

// File: rtl/wm_led_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : wm_led_ctrl
//  Description : Multi-channel front-panel LED controller. Each channel holds
//                a mode (off/on/slow/fast/one-shot) loaded via a write port;
//                blinking channels share one phase-aligned timebase.
//                Optional feature macro: WM_LED_PWM_EN (per-channel 4-bit
//                duty dimming of the lit state).
//  Revision    : 1.0 - initial release
// ============================================================================
module wm_led_ctrl
    import wm_led_pkg::*;
#(
    parameter int NUM_LED       = 12,
    parameter int CNT_1MSEC     = 125000,
    parameter int BLINK_SLOW_MS = 500,
    parameter int BLINK_FAST_MS = 125,
    parameter int ONESHOT_MS    = 1000
) (
    input  logic                                             clk,
    input  logic                                             rstn,
    input  logic                                             cfg_we,
    input  logic [((NUM_LED > 1) ? $clog2(NUM_LED) : 1)-1:0] cfg_idx,
    input  logic [MODE_W-1:0]                                cfg_mode,
    input  logic [DUTY_W-1:0]                                cfg_duty,
    output logic [NUM_LED-1:0]                               led_out,
    output logic                                             tick_1ms
);

    localparam int c_idx_w = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    localparam logic [c_idx_w:0]     c_num_led    = (c_idx_w + 1)'(NUM_LED);
    localparam logic [ONESHOT_W-1:0] c_oneshot_ms = ONESHOT_W'(ONESHOT_MS);

    logic               w_slow_phase;
    logic               w_fast_phase;
    logic               w_idx_ok;
    wm_led_mode_t       w_wr_mode;
    logic [NUM_LED-1:0] w_lit;
    logic [NUM_LED-1:0] r_led;

    wm_led_timebase #(
        .CNT_1MSEC     (CNT_1MSEC),
        .BLINK_SLOW_MS (BLINK_SLOW_MS),
        .BLINK_FAST_MS (BLINK_FAST_MS)
    ) u_timebase (
        .clk        (clk),
        .rstn       (rstn),
        .tick_1ms   (tick_1ms),
        .slow_phase (w_slow_phase),
        .fast_phase (w_fast_phase)
    );

    // Index range check is done once with one spare bit so that NUM_LED
    // values that are not powers of two reject the unused codes.
    assign w_idx_ok  = ({1'b0, cfg_idx} < c_num_led);
    assign w_wr_mode = decode_mode(cfg_mode);

`ifdef WM_LED_PWM_EN
    logic [DUTY_W-1:0] r_pwm_cnt;

    // Free-running PWM counter shared by all channels.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
        end
    end
`else
    logic w_unused_duty;
    assign w_unused_duty = ^cfg_duty;
`endif

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        wm_led_mode_t         r_mode;
        logic [ONESHOT_W-1:0] r_os_cnt;
        logic                 w_wr;

        assign w_wr = cfg_we && w_idx_ok && (cfg_idx == c_idx_w'(i));

        // Mode and one-shot countdown; a write always beats a same-cycle
        // expiry, and any non-one-shot write clears the countdown.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_mode   <= WM_LED_OFF;
                r_os_cnt <= '0;
            end else if (w_wr) begin
                r_mode   <= w_wr_mode;
                r_os_cnt <= (w_wr_mode == WM_LED_ONESHOT) ? c_oneshot_ms : '0;
            end else if ((r_mode == WM_LED_ONESHOT) && tick_1ms) begin
                if (r_os_cnt <= ONESHOT_W'(1)) begin
                    r_mode   <= WM_LED_OFF;
                    r_os_cnt <= '0;
                end else begin
                    r_os_cnt <= r_os_cnt - 1'b1;
                end
            end
        end

`ifdef WM_LED_PWM_EN
        logic [DUTY_W-1:0] r_duty;

        // Duty is captured with every accepted write to this channel.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_duty <= '0;
            end else if (w_wr) begin
                r_duty <= cfg_duty;
            end
        end

        assign w_lit[i] = mode_lit(r_mode, w_slow_phase, w_fast_phase) &
                          (r_pwm_cnt <= r_duty);
`else
        assign w_lit[i] = mode_lit(r_mode, w_slow_phase, w_fast_phase);
`endif
    end

    // Output register keeps the LED pins glitch-free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_led <= '0;
        end else begin
            r_led <= w_lit;
        end
    end

    assign led_out = r_led;

endmodule
`default_nettype wire
